osc_stream_packer: RTL
======================

Name: osc_stream_packer

Overview:
- Sits directly downstream of the multi-channel DDS signal generator.
- Consumes its free-running TDM stream: packed cos/sin word, channel index, valid, sync tlast. The source has no ready.
- Packs the stream into fixed-length AXI-Stream frames through an internal FIFO, for a DMA or other back-pressuring sink.
- Admission is whole-frame only: a frame is dropped entirely, never truncated, when the FIFO cannot hold all of it. Drops are counted.

Parameters:
- G_DATA_W, 32, sample width: {cos[15:0], sin[15:0]}.
- G_CHN_W, 2, channel index width.
- G_FRAME_LEN, 64, beats per output frame; must be a multiple of 2**G_CHN_W and ≤ G_FIFO_DEPTH.
- G_FIFO_DEPTH, 256, FIFO entries; power of 2.
- G_SYNC_ON_TLAST, 0, if 1 the first frame after enable additionally requires i_tlast on the chn-0 beat.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_ena  in  1  capture enable (level).
- i_dat_osc  in  G_DATA_W  sample data.
- i_dat_chn  in  G_CHN_W  sample channel.
- i_vld  in  1  sample valid.
- i_tlast  in  1  generator sync marker.
- m_axis_tdata  out  G_DATA_W  frame data.
- m_axis_tuser  out  G_CHN_W  channel of beat.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tlast  out  1  last beat of frame.
- o_drop_cnt  out  16  dropped frames, saturating at 0xFFFF.
- o_drop  out  1  one-cycle pulse per dropped frame.
- o_fifo_lvl  out  $clog2(G_FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (i_rst=1 at posedge): FSM→IDLE, FIFO flushed, beat counter 0. Outputs held at reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0, o_drop=0, o_drop_cnt=0, o_fifo_lvl=0. Reset mid-frame discards the partial frame, including beats already written.
- Input beat = cycle with i_vld=1. Gaps in i_vld are allowed anywhere; the beat counter advances only on beats.
- SOF candidate = beat with i_dat_chn==0 (and i_tlast=1 in WAIT_SOF when G_SYNC_ON_TLAST=1).
- FSM states:
  - IDLE: ignore input; go to WAIT_SOF when i_ena=1.
  - WAIT_SOF: discard beats until an SOF candidate. On the candidate: if free=G_FIFO_DEPTH−o_fifo_lvl ≥ G_FRAME_LEN, write the beat, cnt=1, go to PASS; else pulse o_drop, increment o_drop_cnt (saturating), cnt=1, go to DROP.
  - PASS: write each beat to the FIFO with tlast=(cnt==G_FRAME_LEN−1). On the last beat go to CHECK logic.
  - DROP: discard beats, counting them. On beat G_FRAME_LEN go to CHECK logic.
  - CHECK logic (state of the next SOF candidate): if i_ena=0 go to IDLE. Otherwise the next beat is evaluated exactly as in WAIT_SOF, with no extra bubble. Frames are back-to-back and stay channel-aligned.
- Deassertion of i_ena mid-frame: the current frame (PASS or DROP) completes; the FSM goes to IDLE afterwards.
- The admission check guarantees no FIFO overflow. Write-when-full is unreachable; implement an assertion that fires on it.
- Simultaneous FIFO read and write in one cycle: o_fifo_lvl is unchanged.
- FIFO behaviour:
  - Input registered one stage before the FIFO write.
  - FIFO is first-word-fall-through.
  - Latency: accepted input beat → m_axis_tvalid = 2 cycles when the FIFO is empty.
  - Output is AXIS compliant: tdata/tuser/tlast stable while tvalid=1 and tready=0. A beat transfers when tvalid&tready.
- o_fifo_lvl is registered and reflects the level after the current cycle's read and write.

Decomposition:
- Package osc_stream_pkg:
  - typedef t_osc_beat {data[G_DATA_W], chn[G_CHN_W], last}.
  - enum t_pack_state {IDLE, WAIT_SOF, PASS, DROP}.
  - DROP_CNT_W=16.
- Sub-module sync_fifo_fwft: parameterized width/depth, registered level, full/empty flags; stores t_osc_beat.

Test Plan:
1. FRAME_LEN=8, DEPTH=16, tready=1, continuous chn 0,1,2,3… from enable → 8 beats with tuser 0,1,2,3,0,1,2,3; tlast only on beat 8; first tvalid 2 cycles after the first accepted beat; frames repeat with no gaps.
2. Enable while the input is at chn=2 → chn 2,3 discarded; first output beat has tuser=0.
3. FRAME_LEN=8, DEPTH=16, tready=0 for 3 frames → frames 1 and 2 stored (o_fifo_lvl=16), frame 3 dropped (o_drop one pulse, o_drop_cnt=1). Then tready=1 → 16 beats out with tlast on beats 8 and 16; frame 4 admitted.
4. i_vld toggling 1-0-1-0 → frame still 8 beats, correct tuser sequence, tdata matches input order.
5. Deassert i_ena at beat 3 of a frame → frame completes (8 beats, tlast), then no further output while disabled.
6. Assert i_rst at beat 5 of a frame with tready=0 → next cycle tvalid=0, o_fifo_lvl=0, o_drop_cnt=0; after release and enable, a clean frame starting at chn 0.

Source files
------------

// File: rtl/osc_stream_pkg.sv
// Shared types for the oscillator stream packer: beat record, FSM states, counter widths.
package osc_stream_pkg;

  localparam int OSC_DATA_W = 32;
  localparam int OSC_CHN_W  = 2;
  localparam int DROP_CNT_W = 16;

  typedef struct packed {
    logic [OSC_DATA_W-1:0] data;
    logic [OSC_CHN_W-1:0]  chn;
    logic                  last;
  } t_osc_beat;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    PASS,
    DROP
  } t_pack_state;

endpackage

// File: rtl/osc_stream_packer_if.sv
// AXI-Stream frame bus: tuser carries the channel of each beat; the slave may stall with tready.
interface osc_stream_packer_if #(
  parameter int DATA_W = 32,
  parameter int CHN_W  = 2
);
  logic [DATA_W-1:0] tdata;
  logic [CHN_W-1:0]  tuser;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: a write is visible on rd_dat the cycle after it lands.
// Reads are ignored while empty; lvl is registered and reflects this cycle's read and write.
module sync_fifo_fwft #(
  parameter int G_WIDTH = 35,
  parameter int G_DEPTH = 256
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       wr_vld,
  input  logic [G_WIDTH-1:0]         wr_dat,
  input  logic                       rd_rdy,
  output logic [G_WIDTH-1:0]         rd_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(G_DEPTH):0]   lvl
);

  localparam int AW = $clog2(G_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   LVL_ONE = 1;

  logic [G_WIDTH-1:0] mem [G_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_rd;

  assign empty  = (lvl == '0);
  assign full   = (lvl == (AW+1)'(G_DEPTH));
  assign do_rd  = rd_rdy && !empty;
  // Empty output reads as zero so the bus is quiet after reset.
  assign rd_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_vld, do_rd})
        2'b10:   lvl <= lvl + LVL_ONE;
        2'b01:   lvl <= lvl - LVL_ONE;
        default: lvl <= lvl;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_vld && !i_rst) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/osc_stream_packer.sv
// Packs the free-running DDS TDM stream into fixed-length AXIS frames, admitting whole frames only.
// Input beat to m_axis.tvalid is 2 cycles through an empty FIFO; tready stalls drain the FIFO only.
module osc_stream_packer import osc_stream_pkg::*; #(
  parameter int G_DATA_W        = OSC_DATA_W,
  parameter int G_CHN_W         = OSC_CHN_W,
  parameter int G_FRAME_LEN     = 64,
  parameter int G_FIFO_DEPTH    = 256,
  parameter int G_SYNC_ON_TLAST = 0
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_ena,
  input  logic [G_DATA_W-1:0]             i_dat_osc,
  input  logic [G_CHN_W-1:0]              i_dat_chn,
  input  logic                            i_vld,
  input  logic                            i_tlast,
  osc_stream_packer_if.master             m_axis,
  output logic [DROP_CNT_W-1:0]           o_drop_cnt,
  output logic                            o_drop,
  output logic [$clog2(G_FIFO_DEPTH):0]   o_fifo_lvl
);

  localparam int LVL_W = $clog2(G_FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(G_FRAME_LEN) + 1;

  t_pack_state        state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               synced;
  logic               at_last, sof_cand, fits;
  logic               take, drop_now, frame_end;
  logic [LVL_W:0]     occ;
  t_osc_beat          stage_beat, fifo_out;
  logic               stage_vld, fifo_full, fifo_empty;

  assign at_last  = (cnt == CNT_W'(G_FRAME_LEN - 1));
  assign sof_cand = i_vld && (i_dat_chn == '0) && ((G_SYNC_ON_TLAST == 0) || i_tlast || synced);
  // The staged beat is not yet counted in the level, so it is added to keep the check exact.
  assign occ      = {1'b0, o_fifo_lvl} + {{LVL_W{1'b0}}, stage_vld};
  assign fits     = (occ <= (LVL_W+1)'(G_FIFO_DEPTH - G_FRAME_LEN));

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (i_ena) state_nxt = WAIT_SOF;
      WAIT_SOF: begin
        if (!i_ena)        state_nxt = IDLE;
        else if (take)     state_nxt = PASS;
        else if (drop_now) state_nxt = DROP;
      end
      PASS, DROP: if (frame_end) state_nxt = i_ena ? WAIT_SOF : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    take      = 1'b0;
    drop_now  = 1'b0;
    frame_end = 1'b0;
    case (state)
      WAIT_SOF: if (i_ena && sof_cand) begin
        take     = fits;
        drop_now = !fits;
      end
      PASS: begin
        take      = i_vld;
        frame_end = i_vld && at_last;
      end
      DROP:    frame_end = i_vld && at_last;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt        <= '0;
      synced     <= 1'b0;
      stage_vld  <= 1'b0;
      stage_beat <= '0;
      o_drop     <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      stage_vld <= take;
      if (take) stage_beat <= '{data: i_dat_osc, chn: i_dat_chn, last: (state == PASS) && at_last};
      o_drop <= drop_now;
      if (drop_now && (o_drop_cnt != '1)) o_drop_cnt <= o_drop_cnt + DROP_CNT_W'(1);
      if (state == IDLE) begin
        cnt    <= '0;
        synced <= 1'b0;
      end else if (state == WAIT_SOF) begin
        if (take || drop_now) begin
          cnt    <= CNT_W'(1);
          synced <= 1'b1;
        end
      end else if (i_vld) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  sync_fifo_fwft #(
    .G_WIDTH ($bits(t_osc_beat)),
    .G_DEPTH (G_FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .wr_vld (stage_vld),
    .wr_dat (stage_beat),
    .rd_rdy (m_axis.tready),
    .rd_dat (fifo_out),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .lvl    (o_fifo_lvl)
  );

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_out.data;
  assign m_axis.tuser  = fifo_out.chn;
  assign m_axis.tlast  = fifo_out.last;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst) !(stage_vld && fifo_full));

endmodule
